// File: rtl/adder_test_logger_if.sv
// Vector/handshake bundle between the exhaustive adder tester (master)
// and the result logger (slave).
interface adder_test_logger_if;
    logic       vec_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       error;
    logic       done;

    modport master (output vec_valid, a, b, cin, error, done);
    modport slave  (input  vec_valid, a, b, cin, error, done);
endinterface

// File: rtl/adder_test_logger.sv
// adder_test_logger: counts vectors and failures from the exhaustive adder
// tester, captures the first failing {cin,b,a}, and latches a PASS/FAIL
// verdict when the tester signals done.
// Optional build macro LOGGER_ORDER_CHECK_EN: each vector must equal
// vec_cnt mod 512; out-of-order vectors count as failures and set order_err.
module adder_test_logger #(
    parameter int EXP_VECTORS = 512,
    parameter int ERR_W       = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    adder_test_logger_if.slave   vif,
    output logic                 busy,
    output logic                 pass,
    output logic                 fail,
    output logic [9:0]           vec_cnt,
    output logic [ERR_W-1:0]     err_cnt,
    output logic                 first_fail_vld,
`ifdef LOGGER_ORDER_CHECK_EN
    output logic                 order_err,
`endif
    output logic [8:0]           first_fail_vec
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t             state, state_nxt;
    logic [9:0]         vec_cnt_nxt;
    logic [ERR_W-1:0]   err_cnt_nxt;
    logic               ffv_nxt;
    logic [8:0]         ffvec_nxt;
    logic [8:0]         vec_in;
    logic               sample;
    logic               bad;

    assign vec_in = {vif.cin, vif.b, vif.a};

    // Vectors are only accepted while a run can still be in progress;
    // PASS/FAIL freeze everything.
    assign sample = vif.vec_valid && (state == S_IDLE || state == S_RUN);

`ifdef LOGGER_ORDER_CHECK_EN
    logic order_mis;
    // Expected index is the running count modulo 512, taken before this vector.
    assign order_mis = (vec_in != vec_cnt[8:0]);
    // An error flag and an order mismatch on the same vector count once.
    assign bad       = vif.error || order_mis;
`else
    assign bad       = vif.error;
`endif

    // Next counter/capture values for the sampled vector (saturating).
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        vec_cnt_nxt = vec_cnt;
        err_cnt_nxt = err_cnt;
        ffv_nxt     = first_fail_vld;
        ffvec_nxt   = first_fail_vec;
        if (sample) begin
            if (vec_cnt != '1)
                vec_cnt_nxt = vec_cnt + 10'd1;
            if (bad) begin
                if (err_cnt != '1)
                    err_cnt_nxt = err_cnt + ERR_W'(1);
                if (!first_fail_vld) begin
                    ffv_nxt   = 1'b1;
                    ffvec_nxt = vec_in;
                end
            end
        end
    end

    // Next-state decode; the verdict uses the counts including a vector
    // sampled on the same edge as done. clear overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (vif.vec_valid) state_nxt = S_RUN;
            S_RUN: begin
                if (vif.done)
                    state_nxt = (err_cnt_nxt == '0 && vec_cnt_nxt == 10'(EXP_VECTORS))
                                ? S_PASS : S_FAIL;
            end
            default: state_nxt = state;
        endcase
        if (clear)
            state_nxt = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Counter and first-fail capture registers; clear zeroes them with priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt        <= '0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (clear) begin
            vec_cnt        <= '0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            vec_cnt        <= vec_cnt_nxt;
            err_cnt        <= err_cnt_nxt;
            first_fail_vld <= ffv_nxt;
            first_fail_vec <= ffvec_nxt;
        end
    end

`ifdef LOGGER_ORDER_CHECK_EN
    // Sticky out-of-order flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            order_err <= 1'b0;
        else if (clear)
            order_err <= 1'b0;
        else if (sample && order_mis)
            order_err <= 1'b1;
    end
`endif

    assign busy = (state == S_RUN);
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);

endmodule
